// File: rtl/sigmoid.sv
`default_nettype none
// ============================================================================
// Module   : sigmoid
// Purpose  : Registered piecewise-linear sigmoid approximation in signed
//            fixed point, one result per clock with a single cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module sigmoid #(
    parameter int BITS = 16,
    parameter int FRAC = 8
) (
    input  logic            clock,
    input  logic            rst,
    input  logic [BITS-1:0] x,
    input  logic            in_valid,
    output logic [BITS-1:0] alfa,
    output logic            out_valid
);

    // Breakpoints and offsets, all scaled by 2^FRAC
    localparam logic [BITS-1:0] c_one     = BITS'(1 << FRAC);
    localparam logic [BITS-1:0] c_sat     = BITS'(5 << FRAC);
    localparam logic [BITS-1:0] c_knee    = BITS'((19 << FRAC) >> 3);
    localparam logic [BITS-1:0] c_off_hi  = BITS'((27 << FRAC) >> 5);
    localparam logic [BITS-1:0] c_off_mid = BITS'((5 << FRAC) >> 3);
    localparam logic [BITS-1:0] c_off_lo  = BITS'(1 << (FRAC - 1));
    localparam logic [BITS-1:0] c_max_pos = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] c_min_neg = {1'b1, {(BITS-1){1'b0}}};

    logic            w_neg;
    logic [BITS-1:0] w_mag;
    logic [BITS-1:0] w_y;
    logic [BITS-1:0] w_res;
    logic [BITS-1:0] alfa_d;
    logic [BITS-1:0] alfa_q;
    logic            out_valid_d;
    logic            out_valid_q;

    always_comb begin
        w_neg = x[BITS-1];
        // The most-negative input has no positive twin, so clamp it
        if (x == c_min_neg) begin
            w_mag = c_max_pos;
        end else if (w_neg) begin
            w_mag = '0 - x;
        end else begin
            w_mag = x;
        end

        if (w_mag >= c_sat) begin
            w_y = c_one;
        end else if (w_mag >= c_knee) begin
            w_y = (w_mag >> 5) + c_off_hi;
        end else if (w_mag >= c_one) begin
            w_y = (w_mag >> 3) + c_off_mid;
        end else begin
            w_y = (w_mag >> 2) + c_off_lo;
        end

        w_res       = w_neg ? (c_one - w_y) : w_y;
        alfa_d      = in_valid ? w_res : alfa_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            alfa_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            alfa_q      <= alfa_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign alfa      = alfa_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sigmoid.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigmoid
// Purpose  : Directed vectors, full sweep, reset and gap sequences for sigmoid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigmoid;

    logic        clock;
    logic        rst;
    logic [15:0] x;
    logic        in_valid;
    logic [15:0] alfa;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [0:11];
    logic [15:0] sweep_res [0:3584];

    sigmoid #(.BITS(16), .FRAC(8)) dut (
        .clock     (clock),
        .rst       (rst),
        .x         (x),
        .in_valid  (in_valid),
        .alfa      (alfa),
        .out_valid (out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Independent reference written with integer arithmetic
    function automatic logic [15:0] model(input logic [15:0] xv);
        int xs, a, y;
        xs = int'($signed(xv));
        if (xs == -32768)   a = 32767;
        else if (xs < 0)    a = -xs;
        else                a = xs;
        if (a >= 1280)      y = 256;
        else if (a >= 608)  y = a / 32 + 216;
        else if (a >= 256)  y = a / 8 + 160;
        else                y = a / 4 + 128;
        if (xs < 0) y = 256 - y;
        return 16'(y);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Drive at negedge, let the rising edge sample, look 1 time unit later
    task automatic step(input logic [15:0] xv, input logic v, input logic r);
        @(negedge clock);
        x        = xv;
        in_valid = v;
        rst      = r;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0]  = '{16'h0000, 16'h0080};
        vecs[1]  = '{16'h0080, 16'h00A0};
        vecs[2]  = '{16'h0100, 16'h00C0};
        vecs[3]  = '{16'hFF00, 16'h0040};
        vecs[4]  = '{16'h025F, 16'h00EB};
        vecs[5]  = '{16'h0260, 16'h00EB};
        vecs[6]  = '{16'h04FF, 16'h00FF};
        vecs[7]  = '{16'h0500, 16'h0100};
        vecs[8]  = '{16'h0700, 16'h0100};
        vecs[9]  = '{16'hF900, 16'h0000};
        vecs[10] = '{16'h8000, 16'h0000};
        vecs[11] = '{16'h7FFF, 16'h0100};

        x = 16'h0000; in_valid = 1'b0; rst = 1'b1;

        // Reset wins over a valid input presented in the same cycle
        step(16'h0100, 1'b1, 1'b1);
        step(16'h0100, 1'b1, 1'b1);
        check("reset_alfa", alfa, 16'h0000);
        check("reset_valid", {15'd0, out_valid}, 16'h0000);
        step(16'h0100, 1'b0, 1'b0);
        check("idle_alfa", alfa, 16'h0000);
        check("idle_valid", {15'd0, out_valid}, 16'h0000);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].x, 1'b1, 1'b0);
            check($sformatf("vec%0d_x%04h", i, vecs[i].x), alfa, vecs[i].exp);
            check($sformatf("vec%0d_valid", i), {15'd0, out_valid}, 16'h0001);
        end

        // Back-to-back sweep from -7.0 to +7.0
        for (int i = 0; i <= 3584; i++) begin
            logic [15:0] xv;
            xv = 16'(i - 1792);
            step(xv, 1'b1, 1'b0);
            sweep_res[i] = alfa;
            check($sformatf("sweep_x%04h", xv), alfa, model(xv));
            if (out_valid !== 1'b1) check("sweep_valid", {15'd0, out_valid}, 16'h0001);
            if (i > 0 && alfa < sweep_res[i-1])
                check($sformatf("mono_x%04h", xv), alfa, sweep_res[i-1]);
        end
        for (int i = 0; i <= 1792; i++) begin
            check($sformatf("sym_%0d", i), 16'(sweep_res[1792 + i] + sweep_res[1792 - i]), 16'h0100);
        end

        // Reset in the middle of a valid stream
        step(16'h0100, 1'b1, 1'b0);
        check("pre_rst_alfa", alfa, 16'h00C0);
        step(16'h0500, 1'b1, 1'b1);
        check("mid_rst_alfa", alfa, 16'h0000);
        check("mid_rst_valid", {15'd0, out_valid}, 16'h0000);
        step(16'h0080, 1'b1, 1'b0);
        check("post_rst_alfa", alfa, 16'h00A0);
        check("post_rst_valid", {15'd0, out_valid}, 16'h0001);

        // One-cycle gap holds the result and drops valid
        step(16'h0700, 1'b0, 1'b0);
        check("gap_alfa", alfa, 16'h00A0);
        check("gap_valid", {15'd0, out_valid}, 16'h0000);
        step(16'hFF00, 1'b1, 1'b0);
        check("resume_alfa", alfa, 16'h0040);
        check("resume_valid", {15'd0, out_valid}, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sigmoid.md
SIGMOID -- requirements
Module: sigmoid

Interface
REQ-001 Parameter: BITS, default 16, total width of input and output words (signed two's complement).
REQ-002 Parameter: FRAC, default 8, number of fractional bits (Q(BITS-FRAC).FRAC); 1.0 = 2^FRAC (0x0100 at defaults).
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: x  input  BITS  signed fixed-point argument.
REQ-006 Port: in_valid  input  1  qualifies x for the current cycle.
REQ-007 Port: alfa  output  BITS  signed fixed-point sigmoid approximation, registered.
REQ-008 Port: out_valid  output  1  high when alfa holds the result of a qualified input.

Function
REQ-009 Magnitude: a = |x|; x = most-negative value (0x8000) SHALL saturate to a = 0x7FFF.
REQ-010 Piecewise positive-half value y(a), all constants scaled by 2^FRAC, shifts arithmetic on a with truncation:
- a >= 5.0 (0x0500): y = 1.0 (0x0100)
- 2.375 (0x0260) <= a < 5.0: y = (a >> 5) + 0.84375 (0x00D8)
- 1.0 (0x0100) <= a < 2.375: y = (a >> 3) + 0.625 (0x00A0)
- a < 1.0: y = (a >> 2) + 0.5 (0x0080)
REQ-011 Sign: x >= 0 gives alfa = y; x < 0 gives alfa = 1.0 - y (0x0100 - y).
REQ-012 Datapath SHALL use only compares, shifts, adds and subtracts; no multipliers, no lookup ROM.
REQ-013 Result range SHALL be 0x0000..0x0100 inclusive; the sign bit of alfa is never set.
REQ-014 Latency: exactly 1 clock; x sampled with in_valid=1 at edge N produces alfa and out_valid=1 after edge N.
REQ-015 in_valid=0 at an edge: out_valid SHALL go 0 and alfa SHALL hold its previous value.
REQ-016 Back-to-back valid inputs SHALL be accepted every cycle, with no stall or backpressure.
REQ-017 Threshold boundaries are inclusive on the upper segment (a = 0x0100 uses the 1/8 slope; a = 0x0260 uses the 1/32 slope; a = 0x0500 gives 1.0).
REQ-018 Symmetry: alfa(x) + alfa(-x) = 0x0100 exactly for every x other than 0x8000.
REQ-019 Output SHALL be monotonically non-decreasing in x over the full signed input range.

Reset
REQ-020 While rst=1 at a rising edge: alfa <= 0x0000 and out_valid <= 0, regardless of in_valid.
REQ-021 In-flight input sampled in the same cycle as rst is discarded; the first valid result appears 1 cycle after the first in_valid=1 edge with rst=0.

Verification
REQ-022 Centre and segments: x = 0x0000 -> 0x0080; 0x0080 -> 0x00A0; 0x0100 -> 0x00C0; 0xFF00 -> 0x0040; each appears 1 cycle after in_valid with out_valid=1.
REQ-023 Breakpoints: x = 0x025F -> 0x00EB; 0x0260 -> 0x00EB; 0x04FF -> 0x00FF; 0x0500 -> 0x0100; 0x0700 -> 0x0100.
REQ-024 Negative saturation: x = 0xF900 -> 0x0000; x = 0x8000 -> 0x0000; x = 0x7FFF -> 0x0100.
REQ-025 Sweep: consecutive in_valid=1 for x = 0xF900..0xFFFF then 0x0000..0x0700, one per cycle. Compare each output against the REQ-010/011 model. Check monotonicity and the REQ-018 symmetry on every pair.
REQ-026 Reset and gaps: assert rst mid-sweep, then check out_valid=0 and alfa=0x0000 on the next cycle. Toggle in_valid=0 for one cycle and check that alfa holds and out_valid drops.
